// File: rtl/serial_shift_acc.sv
// serial_shift_acc: bit-serial shift-accumulate over NCH independent channels.
// A frame consumes nbits partial-sum beats, most significant beat first, and
// yields acc = sum(psum_i * 2^(nbits-1-i)). In signed_mode the first beat
// carries negative weight. All channels share one control path.
// Build option SERIAL_SHIFT_ACC_SAT_EN: every step saturates to OUT_W and
// raises a sticky per-channel ovf flag; without it arithmetic wraps and ovf=0.
module serial_shift_acc #(
  parameter int NCH   = 4,
  parameter int IN_W  = 27,
  parameter int OUT_W = 51,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     nbits,
  input  logic                 signed_mode,
  input  logic                 psum_valid,
  input  logic [NCH*IN_W-1:0]  psum_in,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [NCH*OUT_W-1:0] nout,
  output logic [NCH-1:0]       ovf
);

`ifdef SERIAL_SHIFT_ACC_SAT_EN
  // Two guard bits hold (acc << 1) + psum exactly before clamping.
  localparam int SUM_W = OUT_W + 2;
`else
  localparam int SUM_W = OUT_W;
`endif

  typedef enum logic [1:0] { S_IDLE, S_ACC, S_HOLD } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        nbits_q, nbits_d;
  logic                    smode_q, smode_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] acc_q [NCH];
  logic signed [OUT_W-1:0] acc_d [NCH];
  logic signed [SUM_W-1:0] sum_k [NCH];
  logic signed [OUT_W-1:0] step_acc [NCH];
  logic [NCH*OUT_W-1:0]    nout_q, nout_d;
  logic                    out_valid_q, out_valid_d;
  logic                    load;
  logic                    last_beat;
`ifdef SERIAL_SHIFT_ACC_SAT_EN
  logic [NCH-1:0]          step_ovf;
  logic [NCH-1:0]          ovf_q, ovf_d;
`endif

  // One accumulation step: first beat loads (optionally negated), later beats
  // shift the running value left by one and add the new beat.
  function automatic logic signed [SUM_W-1:0] next_sum(
    input logic signed [OUT_W-1:0] acc,
    input logic signed [IN_W-1:0]  p,
    input logic                    first,
    input logic                    neg
  );
    logic signed [SUM_W-1:0] ext;
    logic signed [SUM_W-1:0] r;
    ext = SUM_W'(p);
    if (first) r = neg ? -ext : ext;
    else       r = (SUM_W'(acc) <<< 1) + ext;
    return r;
  endfunction

`ifdef SERIAL_SHIFT_ACC_SAT_EN
  // Out of range when the guard bits and the OUT_W sign bit disagree.
  function automatic logic sum_ovf(input logic signed [SUM_W-1:0] x);
    return !((&x[SUM_W-1:OUT_W-1]) || !(|x[SUM_W-1:OUT_W-1]));
  endfunction

  // Clamp to the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] x);
    logic signed [OUT_W-1:0] r;
    if (!sum_ovf(x))     r = x[OUT_W-1:0];
    else if (x[SUM_W-1]) r = {1'b1, {(OUT_W-1){1'b0}}};
    else                 r = {1'b0, {(OUT_W-1){1'b1}}};
    return r;
  endfunction
`endif

  // Per-channel arithmetic for the beat currently on psum_in.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sum_k[k] = next_sum(acc_q[k], psum_in[k*IN_W +: IN_W], cnt_q == '0, smode_q);
`ifdef SERIAL_SHIFT_ACC_SAT_EN
      step_acc[k] = sat_out(sum_k[k]);
      step_ovf[k] = sum_ovf(sum_k[k]);
`else
      step_acc[k] = sum_k[k];
`endif
    end
  end

  // Frame control: IDLE/ACC/HOLD next state, beat counting and result capture.
  always_comb begin
    state_d     = state_q;
    nbits_d     = nbits_q;
    smode_d     = smode_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    nout_d      = nout_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_SHIFT_ACC_SAT_EN
    ovf_d       = ovf_q;
`endif
    load        = 1'b0;
    last_beat   = (cnt_q + CNT_W'(1)) == nbits_q;

    unique case (state_q)
      S_IDLE: load = start;
      S_ACC: begin
        if (start) begin
          // Restart aborts the frame in flight; no result is produced.
          load = 1'b1;
        end else if (psum_valid) begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_SHIFT_ACC_SAT_EN
          ovf_d = ovf_q | step_ovf;
`endif
          if (last_beat) begin
            for (int k = 0; k < NCH; k++) nout_d[k*OUT_W +: OUT_W] = step_acc[k];
            out_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // start without out_ready is dropped; with it, hand off and restart.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
          load        = start;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d = S_ACC;
      nbits_d = (nbits == '0) ? CNT_W'(1) : nbits;
      smode_d = signed_mode;
      cnt_d   = '0;
      for (int k = 0; k < NCH; k++) acc_d[k] = '0;
`ifdef SERIAL_SHIFT_ACC_SAT_EN
      ovf_d   = '0;
`endif
    end
  end

  // State and datapath registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      nbits_q     <= '0;
      smode_q     <= 1'b0;
      cnt_q       <= '0;
      for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
      nout_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_SHIFT_ACC_SAT_EN
      ovf_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      nbits_q     <= nbits_d;
      smode_q     <= smode_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      nout_q      <= nout_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_SHIFT_ACC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == S_ACC);
  assign out_valid = out_valid_q;
  assign nout      = nout_q;
`ifdef SERIAL_SHIFT_ACC_SAT_EN
  assign ovf       = ovf_q;
`else
  assign ovf       = '0;
`endif

endmodule

// File: tb/tb_serial_shift_acc.sv
// Bench for serial_shift_acc: a default-width instance and a narrow
// (OUT_W=28) instance share all inputs; results are predicted from beat
// lists with plain weighted-sum arithmetic (or stepwise clamping when the
// saturation build option is defined).
`timescale 1ns/1ps
module tb_serial_shift_acc;
  localparam int NCH   = 4;
  localparam int IN_W  = 27;
  localparam int OW    = 51;
  localparam int ON    = 28;
  localparam int CNT_W = 5;
`ifdef SERIAL_SHIFT_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n, start, signed_mode, psum_valid, out_ready;
  logic [CNT_W-1:0]    nbits;
  logic [NCH*IN_W-1:0] psum_in;
  logic                busy_w, ov_w, busy_n, ov_n;
  logic [NCH*OW-1:0]   nout_w;
  logic [NCH*ON-1:0]   nout_n;
  logic [NCH-1:0]      ovf_w, ovf_n;

  int n_cmp = 0;
  int n_bad = 0;

  longint            beats [NCH][32];
  int                nb_eff;
  bit                sm_cur;
  logic [NCH*OW-1:0] exp_w;
  logic [NCH*ON-1:0] exp_n;
  logic [NCH-1:0]    eovf_w, eovf_n;
  logic [OW-1:0]     tmp_w;
  logic [ON-1:0]     tmp_n;

  always #5 clk = ~clk;

  serial_shift_acc #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OW), .CNT_W(CNT_W)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .nbits(nbits),
    .signed_mode(signed_mode), .psum_valid(psum_valid), .psum_in(psum_in),
    .out_ready(out_ready), .busy(busy_w), .out_valid(ov_w), .nout(nout_w), .ovf(ovf_w));

  serial_shift_acc #(.NCH(NCH), .IN_W(IN_W), .OUT_W(ON), .CNT_W(CNT_W)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .nbits(nbits),
    .signed_mode(signed_mode), .psum_valid(psum_valid), .psum_in(psum_in),
    .out_ready(out_ready), .busy(busy_n), .out_valid(ov_n), .nout(nout_n), .ovf(ovf_n));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint wrap_to(input longint v, input int w);
    longint m, r;
    m = (longint'(1) <<< w) - 1;
    r = v & m;
    if (r[w-1]) r = r - (longint'(1) <<< w);
    return r;
  endfunction

  // Expected channel result for the current beat list at result width w.
  function automatic longint ref_value(input int ch, input int w, output bit ovf_o);
    longint hi, lo, acc, wgt;
    hi    = (longint'(1) <<< (w-1)) - 1;
    lo    = -(longint'(1) <<< (w-1));
    acc   = 0;
    ovf_o = 1'b0;
    if (!SAT) begin
      for (int i = 0; i < nb_eff; i++) begin
        wgt = longint'(1) <<< (nb_eff - 1 - i);
        if (i == 0 && sm_cur) wgt = -wgt;
        acc = acc + wgt * beats[ch][i];
      end
      return wrap_to(acc, w);
    end
    for (int i = 0; i < nb_eff; i++) begin
      if (i == 0) acc = sm_cur ? -beats[ch][0] : beats[ch][0];
      else        acc = 2 * acc + beats[ch][i];
      if (acc > hi) begin acc = hi; ovf_o = 1'b1; end
      if (acc < lo) begin acc = lo; ovf_o = 1'b1; end
    end
    return acc;
  endfunction

  task automatic compute_expected();
    longint v;
    bit     o;
    for (int k = 0; k < NCH; k++) begin
      v = ref_value(k, OW, o);
      exp_w[k*OW +: OW] = v[OW-1:0];
      eovf_w[k] = o;
      v = ref_value(k, ON, o);
      exp_n[k*ON +: ON] = v[ON-1:0];
      eovf_n[k] = o;
    end
  endtask

  function automatic longint rnd_beat();
    logic signed [IN_W-1:0] t;
    int unsigned s;
    s = $urandom_range(0, 7);
    t = IN_W'($urandom);
    if (s == 0)      t = {1'b1, {(IN_W-1){1'b0}}};
    else if (s == 1) t = {1'b0, {(IN_W-1){1'b1}}};
    return longint'(t);
  endfunction

  task automatic clear_beats();
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < 32; i++) beats[k][i] = 0;
  endtask

  task automatic junk_psum();
    for (int k = 0; k < NCH; k++) psum_in[k*IN_W +: IN_W] = IN_W'($urandom);
  endtask

  task automatic set_psum(input int i);
    for (int k = 0; k < NCH; k++) psum_in[k*IN_W +: IN_W] = beats[k][i][IN_W-1:0];
  endtask

  // Start a frame, feed its beats with gaps, and check the result edge.
  task automatic do_frame(input int nb, input bit sm, input int gmin, input int gmax);
    int g;
    start       = 1'b1;
    nbits       = nb[CNT_W-1:0];
    signed_mode = sm;
    psum_valid  = 1'($urandom_range(0, 1));
    junk_psum();
    tick();
    start       = 1'b0;
    nbits       = CNT_W'($urandom);
    signed_mode = 1'($urandom);
    nb_eff      = (nb == 0) ? 1 : nb;
    sm_cur      = sm;
    compute_expected();
    chk("start_busy", 256'(busy_w), 256'(1'b1));
    chk("start_ovf", 256'(ovf_w), 256'(0));
    for (int i = 0; i < nb_eff; i++) begin
      g = $urandom_range(gmin, gmax);
      for (int j = 0; j < g; j++) begin
        psum_valid = 1'b0;
        junk_psum();
        tick();
      end
      if (g > 0) chk("stall_ov", 256'(ov_w), 256'(1'b0));
      psum_valid = 1'b1;
      set_psum(i);
      tick();
      if (i < nb_eff - 1) begin
        chk("mid_ov", 256'(ov_w), 256'(1'b0));
      end else begin
        chk("done_ov_w", 256'(ov_w), 256'(1'b1));
        chk("done_ov_n", 256'(ov_n), 256'(1'b1));
        chk("done_busy", 256'(busy_w), 256'(1'b0));
        chk("nout_w", 256'(nout_w), 256'(exp_w));
        chk("nout_n", 256'(nout_n), 256'(exp_n));
        chk("ovf_w", 256'(ovf_w), 256'(eovf_w));
        chk("ovf_n", 256'(ovf_n), 256'(eovf_n));
      end
    end
    psum_valid = 1'b0;
  endtask

  // Hold the result with out_ready low (beats and a stray start presented),
  // then release it, optionally together with a new start.
  task automatic finish_hold(input int hold_cyc, input bit rel_start);
    for (int c = 0; c < hold_cyc; c++) begin
      out_ready  = 1'b0;
      start      = (c == 1);
      psum_valid = 1'($urandom_range(0, 1));
      junk_psum();
      tick();
      chk("hold_ov", 256'(ov_w), 256'(1'b1));
      chk("hold_busy", 256'(busy_w), 256'(1'b0));
      chk("hold_nout", 256'(nout_w), 256'(exp_w));
    end
    start      = rel_start;
    out_ready  = 1'b1;
    psum_valid = 1'b0;
    tick();
    chk("rel_ov", 256'(ov_w), 256'(1'b0));
    chk("rel_busy", 256'(busy_w), 256'(rel_start));
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; nbits = '0; signed_mode = 1'b0;
    psum_valid = 1'b0; psum_in = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 256'(busy_w), 256'(1'b0));
    chk("rst_ov", 256'(ov_w), 256'(1'b0));
    chk("rst_nout", 256'(nout_w), 256'(0));
    chk("rst_ovf", 256'(ovf_w), 256'(0));
    rst_n = 1'b1;
    psum_valid = 1'b1;
    junk_psum();
    tick();
    chk("idle_ignore_ov", 256'(ov_w), 256'(1'b0));
    chk("idle_busy", 256'(busy_w), 256'(1'b0));
    psum_valid = 1'b0;

    // Unsigned three-beat frame on channel 0.
    clear_beats();
    for (int i = 0; i < 3; i++) beats[0][i] = 24;
    do_frame(3, 1'b0, 0, 0);
    chk("r034_ch0", 256'(nout_w[OW-1:0]), 256'(168));
    chk("r034_others", 256'(nout_w[NCH*OW-1:OW]), 256'(0));
    finish_hold(2, 1'b0);

    // Signed two-beat frame.
    clear_beats();
    beats[1][0] = 1; beats[1][1] = 1; beats[2][0] = 3; beats[2][1] = 0;
    do_frame(2, 1'b1, 0, 0);
    tmp_w = '1;
    chk("r035_ch1", 256'(nout_w[OW +: OW]), 256'(tmp_w));
    tmp_w = OW'(-6);
    chk("r035_ch2", 256'(nout_w[2*OW +: OW]), 256'(tmp_w));
    finish_hold(1, 1'b0);

    // Stalls between beats, long hold, release together with start.
    clear_beats();
    beats[0][0] = 5; beats[0][1] = 0; beats[0][2] = 1;
    do_frame(3, 1'b0, 1, 3);
    chk("r036_ch0", 256'(nout_w[OW-1:0]), 256'(21));
    finish_hold(5, 1'b1);

    // Abort after one beat, then a clean frame.
    start = 1'b1; nbits = 5'd3; signed_mode = 1'b0;
    tick();
    start = 1'b0;
    psum_valid = 1'b1;
    psum_in = '0;
    psum_in[IN_W-1:0] = 27'd7;
    tick();
    chk("abort_ov", 256'(ov_w), 256'(1'b0));
    psum_valid = 1'b0;
    clear_beats();
    for (int i = 0; i < 3; i++) beats[0][i] = 2;
    do_frame(3, 1'b0, 0, 0);
    chk("r038_ch0", 256'(nout_w[OW-1:0]), 256'(14));
    finish_hold(0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    start = 1'b1; nbits = 5'd3;
    tick();
    start = 1'b0;
    psum_valid = 1'b1;
    junk_psum();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 256'(busy_w), 256'(1'b0));
    chk("mrst_ov", 256'(ov_w), 256'(1'b0));
    chk("mrst_nout", 256'(nout_n), 256'(0));
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      junk_psum();
      tick();
      chk("mrst_no_ov", 256'(ov_w), 256'(1'b0));
      chk("mrst_no_busy", 256'(busy_n), 256'(1'b0));
    end
    psum_valid = 1'b0;

    // Narrow instance overflow: clamp or wrap depending on the build.
    clear_beats();
    for (int i = 0; i < 4; i++) beats[0][i] = (longint'(1) <<< 26) - 1;
    do_frame(4, 1'b0, 0, 0);
    tmp_n = SAT ? 28'h7FFFFFF : 28'hBFFFFF1;
    chk("r039_nout", 256'(nout_n[ON-1:0]), 256'(tmp_n));
    chk("r039_ovf", 256'(ovf_n[0]), 256'(SAT));
    finish_hold(1, 1'b0);

    // nbits of zero behaves as a single beat.
    clear_beats();
    for (int k = 0; k < NCH; k++) beats[k][0] = rnd_beat();
    do_frame(0, 1'b1, 0, 1);
    finish_hold(1, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      clear_beats();
      for (int k = 0; k < NCH; k++)
        for (int i = 0; i < 32; i++) beats[k][i] = rnd_beat();
      do_frame($urandom_range(0, 31), 1'($urandom_range(0, 1)), 0, 2);
      finish_hold($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_shift_acc.md
SERIAL_SHIFT_ACC -- requirements
Module: serial_shift_acc

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent accumulation channels.
REQ-002 SHALL have parameter IN_W, default 27, width of each channel's signed partial sum.
REQ-003 SHALL have parameter OUT_W, default 51, width of each channel's signed result; OUT_W > IN_W.
REQ-004 SHALL have parameter CNT_W, default 5, width of the beat counter and nbits.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle pulse that begins a frame.
REQ-008 nbits  input  CNT_W  beats per frame; sampled on an accepted start.
REQ-009 signed_mode  input  1  1 = first beat carries negative (MSB) weight; sampled on an accepted start.
REQ-010 psum_valid  input  1  psum_in carries a valid beat this cycle.
REQ-011 psum_in  input  NCH*IN_W  packed partial sums; channel k occupies bits [k*IN_W +: IN_W].
REQ-012 out_ready  input  1  consumer accepts nout this cycle.
REQ-013 busy  output  1  high in ACC state.
REQ-014 out_valid  output  1  nout holds a completed frame.
REQ-015 nout  output  NCH*OUT_W  packed results, same channel packing as psum_in.
REQ-016 ovf  output  NCH  per-channel overflow flag for the current result.

Function
REQ-017 SHALL implement states IDLE, ACC and HOLD.
REQ-018 IDLE -> ACC on start; the block SHALL latch nbits (a value of 0 SHALL be treated as 1) and signed_mode, and SHALL clear the beat counter, all accumulators and ovf.
REQ-019 In ACC, psum_valid=0 SHALL leave all state unchanged (stall).
REQ-020 In ACC with psum_valid=1, the first beat SHALL load acc = sext(psum) when signed_mode=0, or acc = -sext(psum) when signed_mode=1.
REQ-021 In ACC with psum_valid=1, each later beat SHALL update acc = (acc << 1) + sext(psum), where sext sign-extends IN_W to OUT_W.
REQ-022 On the beat that makes consumed beats equal latched nbits, the block SHALL register the updated acc into nout, set out_valid=1 on the next cycle and enter HOLD.
REQ-023 Latency SHALL be 1 cycle from the last accepted beat to out_valid.
REQ-024 In HOLD, nout and out_valid SHALL stay stable until out_ready=1; on the out_ready cycle the block SHALL clear out_valid and go to IDLE.
REQ-025 start in HOLD coincident with out_ready=1 SHALL complete the handshake and enter ACC per REQ-018 in the same edge.
REQ-026 start in HOLD without out_ready SHALL be ignored.
REQ-027 start in ACC SHALL abort the frame and restart per REQ-018; out_valid SHALL remain 0.
REQ-028 psum_valid SHALL be ignored in IDLE and HOLD.
REQ-029 Channels SHALL be arithmetically independent and SHALL share control.

Reset
REQ-030 On rst_n=0 the block SHALL asynchronously enter IDLE and clear busy=0, out_valid=0, nout=0, ovf=0, the accumulators and the beat counter.
REQ-031 Reset mid-frame SHALL discard the frame; no out_valid SHALL follow.

Configuration
REQ-032 With macro SERIAL_SHIFT_ACC_SAT_EN defined, each accumulation step SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and ovf[k] SHALL be set, sticky until the next accepted start, when channel k saturates.
REQ-033 Without SERIAL_SHIFT_ACC_SAT_EN, arithmetic SHALL wrap modulo 2^OUT_W, ovf SHALL be constant 0, and the ovf port SHALL remain present.

Verification
REQ-034 nbits=3, signed_mode=0, ch0 beats 24,24,24 with psum_valid=1 -> out_valid one cycle after beat 3, ch0 nout=168, other channels 0.
REQ-035 nbits=2, signed_mode=1, ch1 beats 1,1 -> ch1 nout=-1 (all ones, OUT_W bits); ch2 beats 3,0 -> ch2 nout=-6.
REQ-036 nbits=3 with psum_valid=0 gaps between beats 5,0,1 -> ch0 nout=21; a beat presented in HOLD -> nout unchanged.
REQ-037 out_ready held 0 for 5 cycles -> out_valid and nout stable for all 5; out_ready=1 together with start -> out_valid falls, busy rises next cycle.
REQ-038 start re-pulsed after beat 1 of 3, then beats 2,2,2 -> nout=14 only; rst_n pulsed mid-frame -> all outputs 0, no out_valid.
REQ-039 With SERIAL_SHIFT_ACC_SAT_EN, OUT_W=28, nbits=4, beats 2^26-1 each -> nout=2^27-1 and ovf[0]=1; without the macro -> wrapped value and ovf=0.
